// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the store buffer: entry layout, FSM states,
// default depth and word-address helpers.
package store_buffer_pkg;

  localparam int unsigned SB_DEPTH = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
  } sb_entry_t;

  typedef enum logic [0:0] {
    SB_NORMAL = 1'b0,
    SB_FLUSH  = 1'b1
  } sb_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
    return word_align(a) == word_align(b);
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store buffer connection bundle: MEM-stage store port, load forwarding
// lookup, flush handshake and D-cache drain port.
interface store_buffer_if;

  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;

  logic [31:0] ld_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  logic        flush_req;
  logic        flush_ack;

  logic        sb_drain_valid;
  logic [31:0] sb_drain_addr;
  logic [31:0] sb_drain_data;
  logic        sb_drain_done;
  logic        force_drain;
  logic        empty;

  // Pipeline / D-cache side
  modport master (
    output st_valid, st_addr, st_data, ld_addr, flush_req, sb_drain_done,
    input  st_ready, fwd_hit, fwd_data, flush_ack,
    input  sb_drain_valid, sb_drain_addr, sb_drain_data, force_drain, empty
  );

  // Store buffer side
  modport slave (
    input  st_valid, st_addr, st_data, ld_addr, flush_req, sb_drain_done,
    output st_ready, fwd_hit, fwd_data, flush_ack,
    output sb_drain_valid, sb_drain_addr, sb_drain_data, force_drain, empty
  );

endinterface

// File: rtl/store_buffer_fwd_match.sv
// Combinational youngest-match search over the buffered stores for
// store-to-load forwarding.
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = SB_DEPTH,
  localparam int unsigned PW    = $clog2(DEPTH)
) (
  input  sb_entry_t   entries [DEPTH],
  input  logic [PW-1:0] head,
  input  logic [PW:0]   count,
  input  logic [31:0]   ld_addr,
  output logic          hit,
  output logic [31:0]   data
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest; a later match overrides, so the youngest wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (((PW+1)'(i) < count) && entries[idx].valid &&
          word_match(entries[idx].addr, ld_addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular-FIFO store buffer between MEM stage and D-cache, with load
// forwarding and a fence/halt flush that drains every entry.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH
) (
  input logic          clock,
  input logic          reset,
  store_buffer_if.slave sb
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  sb_entry_t     entries [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  sb_state_e     state;
  sb_state_e     state_next;

  logic enq;
  logic deq;
  logic is_empty;

  assign is_empty    = (count == '0);
  assign sb.st_ready = (count < FULL) && (state == SB_NORMAL);
  assign enq         = sb.st_valid && sb.st_ready;
  assign deq         = sb.sb_drain_done && !is_empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= SB_NORMAL;
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (deq) head <= head + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      state <= state_next;
    end
  end

  // Only the valid bits are reset; payload is don't-care until written.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (reset) begin
        entries[i].valid <= 1'b0;
      end else begin
        if (deq && (head == PW'(i))) entries[i].valid <= 1'b0;
        if (enq && (tail == PW'(i))) begin
          entries[i].valid <= 1'b1;
          entries[i].addr  <= word_align(sb.st_addr);
          entries[i].data  <= sb.st_data;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SB_NORMAL: if (sb.flush_req) state_next = SB_FLUSH;
      SB_FLUSH:  if (is_empty)     state_next = SB_NORMAL;
      default:   state_next = SB_NORMAL;
    endcase
  end

  assign sb.empty          = is_empty;
  assign sb.sb_drain_valid = !is_empty;
  assign sb.sb_drain_addr  = is_empty ? '0 : entries[head].addr;
  assign sb.sb_drain_data  = is_empty ? '0 : entries[head].data;
  assign sb.flush_ack      = (state == SB_FLUSH) && is_empty;
  assign sb.force_drain    = (count == FULL) || ((state == SB_FLUSH) && !is_empty);

  sb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
    .entries (entries),
    .head    (head),
    .count   (count),
    .ld_addr (sb.ld_addr),
    .hit     (sb.fwd_hit),
    .data    (sb.fwd_data)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Directed and randomized checks of store_buffer against a queue-based model.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic clock;
  logic reset;

  store_buffer_if sbi ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .sb    (sbi)
  );

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  logic [31:0] mq_addr [$];
  logic [31:0] mq_data [$];
  bit          m_flush = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] la, input logic fr, input logic dd,
                       input logic rst);
    sbi.st_valid      = v;
    sbi.st_addr       = a;
    sbi.st_data       = d;
    sbi.ld_addr       = la;
    sbi.flush_req     = fr;
    sbi.sb_drain_done = dd;
    reset             = rst;
    #1;
  endtask

  task automatic check_model();
    int unsigned sz;
    logic        e_hit;
    logic [31:0] e_fwd;
    sz    = mq_addr.size();
    e_hit = 1'b0;
    e_fwd = '0;
    for (int i = 0; i < int'(sz); i++) begin
      if (mq_addr[i][31:2] == sbi.ld_addr[31:2]) begin
        e_hit = 1'b1;
        e_fwd = mq_data[i];
      end
    end
    chk("st_ready",    {31'b0, sbi.st_ready},       {31'b0, (sz < DEPTH) && !m_flush});
    chk("drain_valid", {31'b0, sbi.sb_drain_valid}, {31'b0, sz != 0});
    chk("drain_addr",  sbi.sb_drain_addr, (sz != 0) ? mq_addr[0] : 32'h0);
    chk("drain_data",  sbi.sb_drain_data, (sz != 0) ? mq_data[0] : 32'h0);
    chk("fwd_hit",     {31'b0, sbi.fwd_hit}, {31'b0, e_hit});
    chk("fwd_data",    sbi.fwd_data, e_fwd);
    chk("force_drain", {31'b0, sbi.force_drain},
        {31'b0, (sz == DEPTH) || (m_flush && sz != 0)});
    chk("flush_ack",   {31'b0, sbi.flush_ack}, {31'b0, m_flush && sz == 0});
    chk("empty",       {31'b0, sbi.empty},     {31'b0, sz == 0});
  endtask

  task automatic tick();
    int unsigned sz;
    bit          rdy;
    bit          nf;
    @(posedge clock);
    if (reset) begin
      mq_addr.delete();
      mq_data.delete();
      m_flush = 1'b0;
    end else begin
      sz  = mq_addr.size();
      rdy = (sz < DEPTH) && !m_flush;
      nf  = m_flush ? (sz != 0) : sbi.flush_req;
      if (sbi.sb_drain_done && sz != 0) begin
        void'(mq_addr.pop_front());
        void'(mq_data.pop_front());
      end
      if (sbi.st_valid && rdy) begin
        mq_addr.push_back({sbi.st_addr[31:2], 2'b00});
        mq_data.push_back(sbi.st_data);
      end
      m_flush = nf;
    end
    #1;
  endtask

  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] la, input logic fr, input logic dd,
                     input logic rst);
    drive(v, a, d, la, fr, dd, rst);
    check_model();
    tick();
  endtask

  initial begin
    logic        v, fr, dd, rst;
    logic [31:0] a, d, la;

    // Reset state
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check_model();
    chk("rst_st_ready",    {31'b0, sbi.st_ready},       32'd1);
    chk("rst_empty",       {31'b0, sbi.empty},          32'd1);
    chk("rst_drain_valid", {31'b0, sbi.sb_drain_valid}, 32'd0);
    chk("rst_drain_addr",  sbi.sb_drain_addr,           32'h0);
    chk("rst_force",       {31'b0, sbi.force_drain},    32'd0);
    chk("rst_ack",         {31'b0, sbi.flush_ack},      32'd0);
    tick();

    // Program-order drain
    cyc(1, 32'h100, 32'hAA, 0, 0, 0, 0);
    cyc(1, 32'h104, 32'hBB, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    check_model();
    chk("order_addr0", sbi.sb_drain_addr, 32'h100);
    chk("order_data0", sbi.sb_drain_data, 32'hAA);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    check_model();
    chk("order_addr1", sbi.sb_drain_addr, 32'h104);
    chk("order_data1", sbi.sb_drain_data, 32'hBB);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("order_empty", {31'b0, sbi.empty}, 32'd1);
    tick();

    // Youngest-match forwarding, no coalescing
    cyc(1, 32'h200, 32'h1, 0, 0, 0, 0);
    cyc(1, 32'h200, 32'h2, 0, 0, 0, 0);
    drive(0, 0, 0, 32'h202, 0, 0, 0);
    check_model();
    chk("fwd_young_hit",  {31'b0, sbi.fwd_hit}, 32'd1);
    chk("fwd_young_data", sbi.fwd_data, 32'h2);
    drive(0, 0, 0, 32'h204, 0, 0, 0);
    check_model();
    chk("fwd_miss_hit",  {31'b0, sbi.fwd_hit}, 32'd0);
    chk("fwd_miss_data", sbi.fwd_data, 32'h0);
    tick();
    drive(0, 0, 0, 32'h200, 0, 1, 0);
    chk("dup_first", sbi.sb_drain_data, 32'h1);
    chk("fwd_draining", {31'b0, sbi.fwd_hit}, 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("dup_second", sbi.sb_drain_data, 32'h2);
    tick();

    // Full buffer backpressure
    for (int i = 0; i < 4; i++) cyc(1, 32'h400 + 32'(i * 4), 32'(i + 16), 0, 0, 0, 0);
    drive(1, 32'h440, 32'h99, 0, 0, 0, 0);
    check_model();
    chk("full_ready", {31'b0, sbi.st_ready},    32'd0);
    chk("full_force", {31'b0, sbi.force_drain}, 32'd1);
    tick();
    cyc(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check_model();
    chk("after_full_ready", {31'b0, sbi.st_ready},    32'd1);
    chk("after_full_force", {31'b0, sbi.force_drain}, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 0);

    // Flush with 3 entries
    for (int i = 0; i < 3; i++) cyc(1, 32'h500 + 32'(i * 4), 32'(i + 32), 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    drive(1, 32'h5F0, 32'h77, 0, 0, 0, 0);
    check_model();
    chk("flush_ready", {31'b0, sbi.st_ready},    32'd0);
    chk("flush_force", {31'b0, sbi.force_drain}, 32'd1);
    tick();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check_model();
    chk("flush_ack_hi", {31'b0, sbi.flush_ack}, 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check_model();
    chk("flush_ack_lo",    {31'b0, sbi.flush_ack}, 32'd0);
    chk("flush_back_norm", {31'b0, sbi.st_ready},  32'd1);
    tick();

    // Flush while empty
    cyc(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check_model();
    chk("empty_flush_ack", {31'b0, sbi.flush_ack}, 32'd1);
    tick();
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Wrap: head now at index 3; simultaneous enqueue and drain
    cyc(1, 32'h604, 32'hC1, 0, 0, 0, 0);
    cyc(1, 32'h608, 32'hC2, 0, 0, 0, 0);
    drive(1, 32'h60C, 32'hC3, 32'h60C, 0, 1, 0);
    check_model();
    chk("enq_no_fwd",   {31'b0, sbi.fwd_hit}, 32'd0);
    chk("wrap_head",    sbi.sb_drain_data, 32'hC1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check_model();
    chk("wrap_next",    sbi.sb_drain_data, 32'hC2);
    tick();
    cyc(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    check_model();
    chk("wrap_last",    sbi.sb_drain_data, 32'hC3);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("wrap_empty",   {31'b0, sbi.empty}, 32'd1);
    tick();

    // Reset during flush
    cyc(1, 32'h700, 32'hD1, 0, 0, 0, 0);
    cyc(1, 32'h704, 32'hD2, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(1, 32'h708, 32'hD3, 0, 1, 1, 1);
    drive(0, 0, 0, 32'h700, 0, 0, 0);
    check_model();
    chk("rstf_empty", {31'b0, sbi.empty},          32'd1);
    chk("rstf_valid", {31'b0, sbi.sb_drain_valid}, 32'd0);
    chk("rstf_ack",   {31'b0, sbi.flush_ack},      32'd0);
    chk("rstf_fwd",   {31'b0, sbi.fwd_hit},        32'd0);
    tick();
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      v   = ($urandom_range(0, 99) < 60);
      a   = 32'h300 + ($urandom_range(0, 7) << 2);
      d   = $urandom;
      la  = 32'h300 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      fr  = ($urandom_range(0, 99) < 5);
      dd  = ($urandom_range(0, 99) < 45);
      rst = ($urandom_range(0, 199) == 0);
      cyc(v, a, d, la, fr, dd, rst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
